midi_event_scheduler: RTL and testbench

//   Time-stamped MIDI event sequencer driven by the free-running 16-bit tick count from timer
//   (out_time -> now_time). Buffers (delta, message) pairs from the sequence parser and releases

---
 rtl/midi_event_scheduler.sv | 170 +++++++++++++++++
 tb/tb_midi_event_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_event_scheduler.sv
// Time-stamped MIDI event sequencer: buffers (delta, message) pairs and releases each
// message on a valid/ready stream once the free-running tick count reaches its deadline.
module midi_event_scheduler #(
  parameter  int unsigned DEPTH  = 8,
  parameter  int unsigned DATA_W = 24,
  parameter  int unsigned TIME_W = 16,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] now_time,
  input  logic              start,
  input  logic              stop,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TIME_W-1:0] in_delta,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              late
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_FIRE
  } state_e;

  state_e              state_q, state_d;
  logic [TIME_W-1:0]   base_q, base_d;
  logic [TIME_W-1:0]   deadline_q, deadline_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                late_q, late_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   data_mem_q  [DEPTH];
  logic [TIME_W-1:0]   delta_mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                full, empty, push, pop;
  logic [TIME_W-1:0]   diff;
  logic                due;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;

  // Modular distance past the deadline; the upper half of the range means "not yet".
  assign diff = now_time - deadline_q;
  assign due  = !diff[TIME_W-1];

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q]  <= in_data;
      delta_mem_q[wr_ptr_q] <= in_delta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Sequencer: stop always wins; a pending handshake still completes in the stop cycle.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    deadline_d = deadline_q;
    data_d     = data_q;
    late_d     = late_q;
    pop        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          base_d  = now_time;
          late_d  = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (!empty && !flush) begin
          pop        = 1'b1;
          deadline_d = base_q + delta_mem_q[rd_ptr_q];
          data_d     = data_mem_q[rd_ptr_q];
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (due) begin
          if (diff != '0) late_d = 1'b1;
          state_d = ST_FIRE;
        end
      end
      ST_FIRE: begin
        if (out_ready) begin
          base_d  = deadline_q;
          state_d = stop ? ST_IDLE : ST_LOAD;
        end else if (stop) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = (state_d == ST_FIRE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      deadline_q  <= '0;
      data_q      <= '0;
      late_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      deadline_q  <= deadline_d;
      data_q      <= data_d;
      late_q      <= late_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign late      = late_q;

endmodule

// File: tb/tb_midi_event_scheduler.sv
// Scoreboard bench for midi_event_scheduler: expected (message, deadline) pairs are queued
// at push time and checked by a monitor whenever a handshake is presented.
module tb_midi_event_scheduler;
  localparam int unsigned TW = 16;
  localparam int unsigned DW = 24;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          clk_en;
  logic          rst;
  logic [TW-1:0] now_time;
  logic          start, stop, flush;
  logic          in_valid, in_ready;
  logic [TW-1:0] in_delta;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic          busy, late;

  midi_event_scheduler #(.DEPTH(8), .DATA_W(DW), .TIME_W(TW)) dut (
    .clk(clk), .rst(rst), .now_time(now_time), .start(start), .stop(stop), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_delta(in_delta), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .busy(busy), .late(late)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] dl;
    int unsigned   slack;
  } exp_t;

  exp_t          sb[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [TW-1:0] model_dl;
  bit            tick_en;
  int            tick_div;
  int            tick_ph;

  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (now_time=%0d)", name, got, exp, now_time);
    end
  endtask

  // Monitor: every accepted message must match the queue head and fire within its window.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got data 0x%0h with empty scoreboard", out_data);
      end else begin
        exp_t          e;
        logic [TW-1:0] d;
        e = sb.pop_front();
        chk("out_data_order", 32'(out_data), 32'(e.data));
        d = now_time - e.dl;
        n_tests++;
        if (32'(d) > e.slack) begin
          n_fail++;
          $display("FAIL fire_time: fired at now_time %0d, required deadline %0d +%0d", now_time, e.dl, e.slack);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (tick_en) begin
        tick_ph++;
        if (tick_ph >= tick_div) begin
          tick_ph  = 0;
          now_time = now_time + 16'd1;
        end
      end
    end
  endtask

  task automatic push(input logic [TW-1:0] d, input logic [DW-1:0] data, input bit track,
                      input int unsigned slack);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_delta = d;
    in_data  = data;
    while (!in_ready && n < 300) begin
      cyc(1);
      n++;
    end
    if (!in_ready) begin
      chk("push_accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      model_dl = model_dl + d;
      if (track) sb.push_back('{data, model_dl, slack});
    end
    cyc(1);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    model_dl = now_time;
    start    = 1'b1;
    cyc(1);
    start    = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      cyc(1);
      n++;
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    clk_en = 1'b1; rst = 1'b1; now_time = '0;
    start = 1'b0; stop = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_delta = '0; in_data = '0; out_ready = 1'b0;
    tick_en = 1'b0; tick_div = 4; tick_ph = 0; model_dl = '0;
    cyc(2);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_late", 32'(late), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    cyc(1);

    // Basic sequence from now_time 100 with a slow tick so every deadline is hit exactly.
    now_time  = 16'd100;
    out_ready = 1'b1;
    do_start();
    chk("t1_busy", 32'(busy), 32'd1);
    push(16'd10, 24'h903C40, 1'b1, 1);
    push(16'd0,  24'h903E40, 1'b1, 1);
    push(16'd5,  24'h803C00, 1'b1, 1);
    tick_en = 1'b1;
    drain("t1_drain", 300);
    chk("t1_late", 32'(late), 32'd0);
    chk("t1_count", 32'(count), 32'd0);
    tick_en = 1'b0;

    // Deadline wraps past 2^16.
    do_stop();
    now_time = 16'd65530;
    do_start();
    push(16'd10, 24'h112233, 1'b1, 1);
    tick_en = 1'b1;
    begin
      int n;
      n = 0;
      while (now_time != 16'd3 && n < 200) begin
        cyc(1);
        n++;
      end
    end
    chk("t2_no_early_fire", 32'(out_valid), 32'd0);
    chk("t2_pending", 32'(sb.size()), 32'd1);
    drain("t2_drain", 200);
    tick_en = 1'b0;

    // FIFO fill: in_ready drops after the eighth event, ninth waits for a pop.
    do_stop();
    out_ready = 1'b1;
    now_time  = 16'd1000;
    model_dl  = 16'd1000;
    for (int i = 0; i < 8; i++) push(16'd0, 24'hA00000 + 24'(i), 1'b1, 0);
    chk("t3_full_ready", 32'(in_ready), 32'd0);
    chk("t3_full_count", 32'(count), 32'd8);
    in_valid = 1'b1;
    in_delta = '0;
    in_data  = 24'hA00008;
    cyc(2);
    chk("t3_ninth_held", 32'(in_ready), 32'd0);
    chk("t3_count_held", 32'(count), 32'd8);
    do_start();
    push(16'd0, 24'hA00008, 1'b1, 0);
    drain("t3_drain", 200);
    chk("t3_count_end", 32'(count), 32'd0);
    chk("t3_late", 32'(late), 32'd0);

    // Late handshake: deadline 200 seen only at 220; next event measured from 200.
    do_stop();
    out_ready = 1'b0;
    now_time  = 16'd190;
    do_start();
    push(16'd10, 24'h904840, 1'b1, 25);
    push(16'd5,  24'h804800, 1'b1, 30);
    cyc(3);
    chk("t4_not_due", 32'(out_valid), 32'd0);
    now_time = 16'd220;
    cyc(3);
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_data", 32'(out_data), 32'h904840);
    chk("t4_late", 32'(late), 32'd1);
    cyc(4);
    chk("t4_valid_held", 32'(out_valid), 32'd1);
    chk("t4_data_stable", 32'(out_data), 32'h904840);
    out_ready = 1'b1;
    drain("t4_drain", 50);
    chk("t4_count_end", 32'(count), 32'd0);

    // stop while waiting keeps FIFO contents; flush empties it.
    do_stop();
    out_ready = 1'b0;
    do_start();
    push(16'd100, 24'hC01111, 1'b0, 0);
    push(16'd50,  24'hC02222, 1'b0, 0);
    cyc(2);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_count", 32'(count), 32'd1);
    do_stop();
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_count_kept", 32'(count), 32'd1);
    flush = 1'b1;
    #1;
    chk("t5_flush_ready", 32'(in_ready), 32'd0);
    cyc(1);
    flush = 1'b0;
    chk("t5_flushed", 32'(count), 32'd0);

    // Asynchronous reset during FIRE with the clock stopped.
    do_start();
    push(16'd0, 24'h90AA55, 1'b0, 0);
    push(16'd0, 24'h90BB55, 1'b0, 0);
    cyc(3);
    chk("t6_fire", 32'(out_valid), 32'd1);
    chk("t6_count", 32'(count), 32'd1);
    clk_en = 1'b0;
    @(negedge clk);
    #20;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_count", 32'(count), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    #10;
    clk_en = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);

    chk("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
